// File: rtl/sys_clk_divgen_pkg.sv
// Shared types for the multi-channel clock generator: FSM states, the
// per-channel configuration record and its reset default.
package sys_clk_divgen_pkg;

  typedef enum logic [1:0] {LOAD, ALIGN, SETTLE, LOCKED} state_t;

  // Field width of the configuration record; the top-level CNT_W defaults to it.
  localparam int CFG_W = 16;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } ch_cfg_t;

  localparam ch_cfg_t DEF_CFG = '{div: CFG_W'(2), high: CFG_W'(1), phase: CFG_W'(0)};

  // High time forced into 1..div-1 so neither level of the output can vanish.
  function automatic logic [CFG_W-1:0] clamp_high(input ch_cfg_t c);
    if (c.high == '0) return CFG_W'(1);
    if (c.high >= c.div) return c.div - CFG_W'(1);
    return c.high;
  endfunction

endpackage

// File: rtl/sys_clk_divgen_ch.sv
// One output channel: active configuration, run flag, period counter and
// registered clock / clock-enable outputs.
module sys_clk_divgen_ch
  import sys_clk_divgen_pkg::*;
#(
  parameter ch_cfg_t DEF = DEF_CFG
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             align,
  input  logic [CFG_W-1:0] align_cnt,
  input  ch_cfg_t          shadow,
  output logic             running,
  output logic             clk_out,
  output logic             ce_out
);

  ch_cfg_t          act;
  logic             run;
  logic [CFG_W-1:0] cnt;
  logic             en;
  logic [CFG_W-1:0] high_eff;

  assign en       = (act.div >= CFG_W'(2));
  assign high_eff = clamp_high(act);
  // A disabled channel never holds up alignment.
  assign running  = run || !en;

  // Outputs are registered from the current counter, so a channel that starts
  // at one edge shows its first pulse after the following edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= DEF;
      run     <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      ce_out  <= 1'b0;
    end else if (load) begin
      act     <= shadow;
      run     <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      ce_out  <= 1'b0;
    end else begin
      ce_out  <= run && (cnt == '0);
      clk_out <= run && (cnt < high_eff);
      if (run) begin
        cnt <= (cnt == act.div - CFG_W'(1)) ? '0 : cnt + CFG_W'(1);
      end else if (align && en && (align_cnt == act.phase)) begin
        run <= 1'b1;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sys_clk_divgen.sv
// Multi-channel programmable clock generator: shadow configuration bank,
// LOAD/ALIGN/SETTLE/LOCKED control and the per-channel dividers.
module sys_clk_divgen
  import sys_clk_divgen_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = CFG_W,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = int'(DEF_CFG.div),
  parameter int DEF_HIGH    = int'(DEF_CFG.high),
  parameter int DEF_PHASE   = int'(DEF_CFG.phase)
) (
  input  logic                                     refclk,
  input  logic                                     rst_n,
  input  logic                                     cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                         cfg_div,
  input  logic [CNT_W-1:0]                         cfg_high,
  input  logic [CNT_W-1:0]                         cfg_phase,
  input  logic                                     cfg_apply,
  output logic [N_CH-1:0]                          clk_out,
  output logic [N_CH-1:0]                          ce_out,
  output logic                                     locked
);

  localparam ch_cfg_t DEF = '{div: CFG_W'(DEF_DIV), high: CFG_W'(DEF_HIGH),
                              phase: CFG_W'(DEF_PHASE)};
  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  state_t            state;
  logic              boot;
  logic              apply;
  logic [CNT_W-1:0]  align_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              settle_done;
  logic [N_CH-1:0]   running;
  logic              all_run;
  ch_cfg_t           shadow [N_CH];

  // Reset behaves like an apply seen on the first edge, so power-up and a
  // later cfg_apply follow the same timeline.
  assign apply       = cfg_apply || boot;
  assign all_run     = &running;
  assign settle_done = (settle_cnt == SET_W'(LOCK_CYCLES - 1));

  // Out-of-range channel indices match no entry and are dropped.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= DEF;
    end else if (cfg_we) begin
      for (int i = 0; i < N_CH; i++) begin
        if (int'(cfg_ch) == i) begin
          shadow[i] <= '{div: CFG_W'(cfg_div), high: CFG_W'(cfg_high),
                         phase: CFG_W'(cfg_phase)};
        end
      end
    end
  end

  // Apply overrides whatever transition the current state would take.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      boot       <= 1'b1;
      align_cnt  <= '0;
      settle_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      boot   <= 1'b0;
      locked <= (state == LOCKED) || ((state == SETTLE) && settle_done && !apply);
      case (state)
        LOAD: begin
          align_cnt <= '0;
          state     <= ALIGN;
        end
        ALIGN: begin
          if (align_cnt != '1) align_cnt <= align_cnt + CNT_W'(1);
          if (all_run) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done) state <= LOCKED;
          else settle_cnt <= settle_cnt + SET_W'(1);
        end
        LOCKED: state <= LOCKED;
        default: state <= LOAD;
      endcase
      if (apply) state <= LOAD;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sys_clk_divgen_ch #(.DEF(DEF)) u_ch (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .load      (state == LOAD),
      .align     (state == ALIGN),
      .align_cnt (CFG_W'(align_cnt)),
      .shadow    (shadow[g]),
      .running   (running[g]),
      .clk_out   (clk_out[g]),
      .ce_out    (ce_out[g])
    );
  end

endmodule

// File: tb/tb_sys_clk_divgen.sv
// Directed bench for sys_clk_divgen with three channels; every expected
// output vector below is worked out by hand from the edge timeline.
module tb_sys_clk_divgen;

  logic        refclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [15:0] cfg_high = '0;
  logic [15:0] cfg_phase = '0;
  logic        cfg_apply = 1'b0;
  logic [2:0]  clk_out;
  logic [2:0]  ce_out;
  logic        locked;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  sys_clk_divgen #(
    .N_CH(3), .CNT_W(16), .LOCK_CYCLES(16),
    .DEF_DIV(2), .DEF_HIGH(1), .DEF_PHASE(0)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .cfg_apply (cfg_apply),
    .clk_out   (clk_out),
    .ce_out    (ce_out),
    .locked    (locked)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Drives one configuration cycle; the edge that samples it is consumed here.
  task automatic apply_stimulus(input logic we, input logic [1:0] ch, input logic [15:0] div,
                                input logic [15:0] high, input logic [15:0] phase,
                                input logic apply);
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_high  = high;
    cfg_phase = phase;
    cfg_apply = apply;
    tick();
    cfg_we    = 1'b0;
    cfg_apply = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [2:0] clk_e,
                              input logic [2:0] ce_e, input logic lock_e);
    checks++;
    assert ({clk_out, ce_out, locked} === {clk_e, ce_e, lock_e}) else begin
      errors++;
      $error("[TB] FAIL %s: clk_out=%b ce_out=%b locked=%b, expected clk_out=%b ce_out=%b locked=%b",
             tag, clk_out, ce_out, locked, clk_e, ce_e, lock_e);
    end
  endtask

  initial begin
    // Power-up defaults: div 2, high 1, phase 0 on all channels.
    #3;
    check_output("reset", 3'b000, 3'b000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(2);
    tick();  check_output("def_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("def_e3", 3'b111, 3'b111, 1'b0);
    tick();  check_output("def_e4", 3'b000, 3'b000, 1'b0);
    tick();  check_output("def_e5", 3'b111, 3'b111, 1'b0);
    tick(13); check_output("def_e18", 3'b000, 3'b000, 1'b0);
    tick();  check_output("def_e19", 3'b111, 3'b111, 1'b1);

    $display("[TB] phase offsets");
    apply_stimulus(1'b1, 2'd0, 16'd4, 16'd2, 16'd0, 1'b0);
    apply_stimulus(1'b1, 2'd1, 16'd4, 16'd1, 16'd3, 1'b0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_output("ph_e0", 3'b000, 3'b000, 1'b1);
    tick();  check_output("ph_e1", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ph_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ph_e3", 3'b101, 3'b101, 1'b0);
    tick();  check_output("ph_e4", 3'b001, 3'b000, 1'b0);
    tick();  check_output("ph_e5", 3'b100, 3'b100, 1'b0);
    tick();  check_output("ph_e6", 3'b010, 3'b010, 1'b0);
    tick();  check_output("ph_e7", 3'b101, 3'b101, 1'b0);
    tick();  check_output("ph_e8", 3'b001, 3'b000, 1'b0);
    tick(2); check_output("ph_e10", 3'b010, 3'b010, 1'b0);
    tick();  check_output("ph_e11", 3'b101, 3'b101, 1'b0);
    tick(10); check_output("ph_e21", 3'b100, 3'b100, 1'b0);
    tick();  check_output("ph_e22", 3'b010, 3'b010, 1'b1);

    $display("[TB] clamp and disable");
    apply_stimulus(1'b1, 2'd0, 16'd5, 16'd9, 16'd0, 1'b0);
    apply_stimulus(1'b1, 2'd1, 16'd1, 16'd0, 16'd0, 1'b0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_output("cl_e0", 3'b100, 3'b100, 1'b1);
    tick();  check_output("cl_e1", 3'b000, 3'b000, 1'b0);
    tick();  check_output("cl_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("cl_e3", 3'b101, 3'b101, 1'b0);
    tick();  check_output("cl_e4", 3'b001, 3'b000, 1'b0);
    tick();  check_output("cl_e5", 3'b101, 3'b100, 1'b0);
    tick();  check_output("cl_e6", 3'b001, 3'b000, 1'b0);
    tick();  check_output("cl_e7", 3'b100, 3'b100, 1'b0);
    tick();  check_output("cl_e8", 3'b001, 3'b001, 1'b0);
    tick(10); check_output("cl_e18", 3'b001, 3'b001, 1'b0);
    tick();  check_output("cl_e19", 3'b101, 3'b100, 1'b1);

    $display("[TB] re-apply during alignment");
    apply_stimulus(1'b1, 2'd1, 16'd4, 16'd1, 16'd3, 1'b0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_output("ra_e0", 3'b101, 3'b100, 1'b1);
    tick();  check_output("ra_e1", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ra_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ra_e3", 3'b101, 3'b101, 1'b0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_output("ra2_e0", 3'b001, 3'b000, 1'b0);
    tick();  check_output("ra2_e1", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ra2_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("ra2_e3", 3'b101, 3'b101, 1'b0);
    tick();  check_output("ra2_e4", 3'b001, 3'b000, 1'b0);
    tick();  check_output("ra2_e5", 3'b101, 3'b100, 1'b0);
    tick();  check_output("ra2_e6", 3'b011, 3'b010, 1'b0);
    tick(15); check_output("ra2_e21", 3'b101, 3'b100, 1'b0);
    tick();  check_output("ra2_e22", 3'b010, 3'b010, 1'b1);

    $display("[TB] write/apply collision");
    apply_stimulus(1'b1, 2'd1, 16'd8, 16'd3, 16'd0, 1'b1);
    check_output("co_e0", 3'b101, 3'b101, 1'b1);
    tick();  check_output("co_e1", 3'b000, 3'b000, 1'b0);
    tick(2); check_output("co_e3", 3'b111, 3'b111, 1'b0);
    tick(7); check_output("co_e10", 3'b001, 3'b000, 1'b0);
    tick();  check_output("co_e11", 3'b111, 3'b110, 1'b0);
    tick(7); check_output("co_e18", 3'b001, 3'b001, 1'b0);
    tick();  check_output("co_e19", 3'b111, 3'b110, 1'b1);

    $display("[TB] out-of-range channel write");
    apply_stimulus(1'b1, 2'd3, 16'd3, 16'd1, 16'd5, 1'b0);
    apply_stimulus(1'b0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    check_output("bi_e0", 3'b111, 3'b100, 1'b1);
    tick();  check_output("bi_e1", 3'b000, 3'b000, 1'b0);
    tick(2); check_output("bi_e3", 3'b111, 3'b111, 1'b0);
    tick(8); check_output("bi_e11", 3'b111, 3'b110, 1'b0);
    tick(7); check_output("bi_e18", 3'b001, 3'b001, 1'b0);
    tick();  check_output("bi_e19", 3'b111, 3'b110, 1'b1);

    $display("[TB] asynchronous reset while locked");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_rst", 3'b000, 3'b000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick(2);
    tick();  check_output("rr_e2", 3'b000, 3'b000, 1'b0);
    tick();  check_output("rr_e3", 3'b111, 3'b111, 1'b0);
    tick();  check_output("rr_e4", 3'b000, 3'b000, 1'b0);
    tick(14); check_output("rr_e18", 3'b000, 3'b000, 1'b0);
    tick();  check_output("rr_e19", 3'b111, 3'b111, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
